alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 117 +++++++++++
 tb/tb_alu_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a single shared ALU.
// One operation is in flight at a time: grant (IDLE) -> execute (EXEC) -> respond (RESP).
module alu_arbiter #(
  parameter int unsigned NUM_OPS = 6
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [4:0]  req0_opcode,
  input  logic [4:0]  req1_opcode,
  input  logic [4:0]  req0_shamt,
  input  logic [4:0]  req1_shamt,
  input  logic [31:0] req0_opA,
  input  logic [31:0] req0_opB,
  input  logic [31:0] req1_opA,
  input  logic [31:0] req1_opB,
  output logic [31:0] alu_opA,
  output logic [31:0] alu_opB,
  output logic [4:0]  alu_opcode,
  output logic [4:0]  alu_shamt,
  input  logic [31:0] alu_result,
  input  logic        alu_ne,
  input  logic        alu_lt,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_ne,
  output logic        rsp_lt,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 5;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   pri;
  logic   grant0, grant1;
  logic   accept;
  logic   cap_id;
  logic   op_illegal;

  // Round-robin: pri only matters when both requesters are valid
  always_comb begin
    grant0 = req0_valid && (!req1_valid || !pri);
    grant1 = req1_valid && (!req0_valid ||  pri);
  end

  assign accept     = (state == IDLE) && (grant0 || grant1);
  assign req0_ready = reset_n && (state == IDLE) && grant0;
  assign req1_ready = reset_n && (state == IDLE) && grant1;
  assign op_illegal = 32'(alu_opcode) >= NUM_OPS;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Captured operation doubles as the ALU drive, so it holds outside EXEC
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pri        <= 1'b0;
      cap_id     <= 1'b0;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_opcode <= '0;
      alu_shamt  <= '0;
    end else if (accept) begin
      pri        <= !grant1;
      cap_id     <= grant1;
      alu_opA    <= grant1 ? req1_opA    : req0_opA;
      alu_opB    <= grant1 ? req1_opB    : req0_opB;
      alu_opcode <= grant1 ? req1_opcode : req0_opcode;
      alu_shamt  <= grant1 ? req1_shamt  : req0_shamt;
    end
  end

  // Response capture at the end of EXEC; cleared on handshake
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_ne    <= 1'b0;
      rsp_lt    <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state == EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= cap_id;
      rsp_data  <= op_illegal ? DATA_W'(0) : alu_result;
      rsp_ne    <= !op_illegal && alu_ne;
      rsp_lt    <= !op_illegal && alu_lt;
      rsp_err   <= op_illegal;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, OP_W[0]};

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model plus directed scenarios.
module tb_alu_arbiter;

  logic        clock, reset_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [4:0]  req0_opcode, req1_opcode, req0_shamt, req1_shamt;
  logic [31:0] req0_opA, req0_opB, req1_opA, req1_opB;
  logic [31:0] alu_opA, alu_opB, alu_result;
  logic [4:0]  alu_opcode, alu_shamt;
  logic        alu_ne, alu_lt;
  logic        rsp_valid, rsp_id, rsp_ne, rsp_lt, rsp_err, rsp_ready;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.NUM_OPS(6)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_opcode(req0_opcode), .req1_opcode(req1_opcode),
    .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
    .req0_opA(req0_opA), .req0_opB(req0_opB),
    .req1_opA(req1_opA), .req1_opB(req1_opB),
    .alu_opA(alu_opA), .alu_opB(alu_opB),
    .alu_opcode(alu_opcode), .alu_shamt(alu_shamt),
    .alu_result(alu_result), .alu_ne(alu_ne), .alu_lt(alu_lt),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ne(rsp_ne), .rsp_lt(rsp_lt), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a & b;
      5'd3:    return a | b;
      5'd4:    return a << sh;
      5'd5:    return 32'($signed(a) >>> sh);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  // Shared ALU stand-in; junk result on illegal opcodes must never reach rsp_data
  assign alu_result = alu_f(alu_opcode, alu_opA, alu_opB, alu_shamt);
  assign alu_ne     = alu_opA != alu_opB;
  assign alu_lt     = $signed(alu_opA) < $signed(alu_opB);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: busy flag, cycles since grant, and the expected response
  logic        m_busy, m_pri, m_id, m_ne, m_lt, m_err, e0, e1;
  int          m_age;
  logic [31:0] m_data, m_a, m_b;
  logic [4:0]  m_op, m_sh;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_req0_ready", 32'(req0_ready), 0);
      check("rst_req1_ready", 32'(req1_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp", {rsp_id, rsp_ne, rsp_lt, rsp_err}, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_alu_ops", alu_opA | alu_opB, 0);
      check("rst_alu_ctl", {alu_opcode, alu_shamt}, 0);
      m_busy = 0; m_age = 0; m_pri = 0; m_id = 0;
      m_a = 0; m_b = 0; m_op = 0; m_sh = 0;
    end else begin
      e0 = !m_busy && req0_valid && (!req1_valid || !m_pri);
      e1 = !m_busy && req1_valid && (!req0_valid ||  m_pri);
      check("m_req0_ready", 32'(req0_ready), 32'(e0));
      check("m_req1_ready", 32'(req1_ready), 32'(e1));
      check("m_alu_opA", alu_opA, m_a);
      check("m_alu_opB", alu_opB, m_b);
      check("m_alu_ctl", {alu_opcode, alu_shamt}, {m_op, m_sh});
      check("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age == 2));
      if (m_busy && m_age == 2) begin
        check("m_rsp_id", 32'(rsp_id), 32'(m_id));
        check("m_rsp_data", rsp_data, m_data);
        check("m_rsp_flags", {rsp_ne, rsp_lt, rsp_err}, {m_ne, m_lt, m_err});
      end
      if (e0 || e1) begin
        m_id = e1;
        m_pri = !e1;
        m_a  = e1 ? req1_opA : req0_opA;
        m_b  = e1 ? req1_opB : req0_opB;
        m_op = e1 ? req1_opcode : req0_opcode;
        m_sh = e1 ? req1_shamt : req0_shamt;
        m_err  = m_op >= 5'd6;
        m_data = m_err ? 32'd0 : alu_f(m_op, m_a, m_b, m_sh);
        m_ne   = !m_err && (m_a != m_b);
        m_lt   = !m_err && ($signed(m_a) < $signed(m_b));
        m_busy = 1; m_age = 1;
      end else if (m_busy && m_age == 1) begin
        m_age = 2;
      end else if (m_busy && m_age == 2 && rsp_ready) begin
        m_busy = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic wait_rsp(input string name);
    logic seen;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clock);
      seen = rsp_valid;
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
  endtask

  task automatic set_req(input logic id, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
    if (id) begin
      req1_valid = 1; req1_opcode = op; req1_opA = a; req1_opB = b; req1_shamt = sh;
    end else begin
      req0_valid = 1; req0_opcode = op; req0_opA = a; req0_opB = b; req0_shamt = sh;
    end
  endtask

  int          g_cyc[$];
  logic        g_id[$];
  logic [31:0] held;
  int          n_rdy;

  initial begin
    reset_n = 0; rsp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    req0_opcode = 0; req1_opcode = 0; req0_shamt = 0; req1_shamt = 0;
    req0_opA = 0; req0_opB = 0; req1_opA = 0; req1_opB = 0;
    repeat (2) @(negedge clock);
    check("reset_rsp_valid", 32'(rsp_valid), 0);

    // Single add from requester 0: ready in N, ALU driven in N+1, response in N+2
    tick(); reset_n = 1;
    set_req(0, 5'd0, 32'd5, 32'd7, 5'd0);
    @(negedge clock); check("single_ready", 32'(req0_ready), 1);
    tick(); req0_valid = 0;
    @(negedge clock); check("single_alu_op", {27'd0, alu_opcode}, 0);
    check("single_alu_opA", alu_opA, 32'd5);
    @(negedge clock); check("single_rsp_valid", 32'(rsp_valid), 1);
    check("single_rsp_id", 32'(rsp_id), 0);
    check("single_rsp_data", rsp_data, 32'd12);
    check("single_rsp_flags", {rsp_ne, rsp_lt, rsp_err}, 3'b110);

    // Backpressure on sub 3-3 while requester 1 waits
    tick(); rsp_ready = 0;
    set_req(0, 5'd1, 32'd3, 32'd3, 5'd0);
    @(negedge clock); check("bp_ready", 32'(req0_ready), 1);
    tick(); req0_valid = 0;
    set_req(1, 5'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0);
    wait_rsp("bp");
    check("sub_rsp_data", rsp_data, 32'd0);
    check("sub_rsp_ne", 32'(rsp_ne), 0);
    held = rsp_data; n_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      n_rdy += int'(req0_ready) + int'(req1_ready);
      check("bp_hold_data", rsp_data, held);
      check("bp_hold_valid", 32'(rsp_valid), 1);
    end
    check("bp_no_grant", 32'(n_rdy), 0);
    tick(); rsp_ready = 1;
    @(negedge clock); check("bp_still_resp", 32'(req1_ready), 0);
    @(negedge clock); check("bp_next_grant", 32'(req1_ready), 1);
    tick(); req1_valid = 0;
    wait_rsp("and");
    check("and_rsp_id", 32'(rsp_id), 1);
    check("and_rsp_data", rsp_data, 32'h0F0F_0000);

    // Illegal opcode from requester 1, then a legal sra
    tick(); set_req(1, 5'b01010, 32'd123, 32'd456, 5'd0);
    tick(); req1_valid = 0;
    wait_rsp("illegal");
    check("illegal_err", 32'(rsp_err), 1);
    check("illegal_data", rsp_data, 32'd0);
    check("illegal_id", 32'(rsp_id), 1);
    tick(); set_req(1, 5'd5, 32'h8000_0000, 32'd0, 5'd4);
    tick(); req1_valid = 0;
    wait_rsp("sra");
    check("sra_data", rsp_data, 32'hF800_0000);
    check("sra_err", 32'(rsp_err), 0);

    // Contention after reset: 0,1,0,1 three cycles apart
    tick(); reset_n = 0;
    @(negedge clock);
    tick(); reset_n = 1;
    set_req(0, 5'd0, 32'd1, 32'd2, 5'd0);
    set_req(1, 5'd3, 32'd4, 32'd8, 5'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (req0_ready) begin g_cyc.push_back(i); g_id.push_back(0); end
      if (req1_ready) begin g_cyc.push_back(i); g_id.push_back(1); end
    end
    tick(); req0_valid = 0; req1_valid = 0;
    check("cont_grants", 32'(g_cyc.size()), 4);
    if (g_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("cont_id", 32'(g_id[i]), 32'(i % 2));
        if (i > 0) check("cont_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 3);
      end
    end
    repeat (4) tick();

    // Reset during EXEC: aborted op never responds; lone req1 granted first
    set_req(0, 5'd0, 32'd9, 32'd9, 5'd0);
    @(negedge clock); check("abort_ready", 32'(req0_ready), 1);
    tick(); req0_valid = 0; reset_n = 0;
    set_req(1, 5'd0, 32'd20, 32'd22, 5'd0);
    #1;
    check("abort_async_alu", alu_opA, 32'd0);
    check("abort_async_valid", 32'(rsp_valid), 0);
    check("abort_async_ready", 32'(req1_ready), 0);
    @(negedge clock);
    tick(); reset_n = 1;
    @(negedge clock); check("post_rst_req1", 32'(req1_ready), 1);
    tick(); req1_valid = 0;
    wait_rsp("post_rst");
    check("post_rst_id", 32'(rsp_id), 1);
    check("post_rst_data", rsp_data, 32'd42);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
